// File: rtl/rr_arbiter8_if.sv
// Request/grant bundle between the requesters and the eight-way round-robin arbiter.
// The arbiter takes the slave side; the requesters or the bench take the master side.
interface rr_arbiter8_if;
  logic       en;
  logic [7:0] req;
  logic       done;
  logic [2:0] grant_idx;
  logic       grant_valid;
  logic       busy;
  logic       timeout;

  modport master (
    output en, req, done,
    input  grant_idx, grant_valid, busy, timeout
  );

  modport slave (
    input  en, req, done,
    output grant_idx, grant_valid, busy, timeout
  );
endinterface

// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with grant hold and a hold-time watchdog.
// It registers a 3-bit grant index that feeds a downstream 3-to-8 decoder.
module rr_arbiter8 #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned HOLD_W   = 8
) (
  input logic          clk,
  input logic          rst_n,
  rr_arbiter8_if.slave bus
);

  typedef enum logic {StIdle, StGrant} state_e;

  state_e            state_q;
  logic [2:0]        ptr_q;
  logic [2:0]        grant_idx_q;
  logic [HOLD_W-1:0] hold_cnt_q;
  logic              timeout_q;

  logic [2:0] winner;
  logic [2:0] cand;
  logic       hit;

  // Rotating scan: the first set request at or after ptr wins.
  always_comb begin
    winner = ptr_q;
    cand   = ptr_q;
    hit    = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cand = ptr_q + 3'(i);
      if (!hit && bus.req[cand]) begin
        winner = cand;
        hit    = 1'b1;
      end
    end
  end

  logic owner_req;
  logic cnt_expired;
  logic release_now;

  assign owner_req   = bus.req[grant_idx_q];
  assign cnt_expired = (hold_cnt_q == HOLD_W'(MAX_HOLD - 1));
  assign release_now = bus.done || !owner_req || cnt_expired;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      ptr_q       <= 3'd0;
      grant_idx_q <= 3'd0;
      hold_cnt_q  <= '0;
      timeout_q   <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.en && hit) begin
            grant_idx_q <= winner;
            hold_cnt_q  <= '0;
            state_q     <= StGrant;
          end
        end
        StGrant: begin
          if (release_now) begin
            state_q    <= StIdle;
            ptr_q      <= grant_idx_q + 3'd1;
            hold_cnt_q <= '0;
            // Flag only a release forced purely by the watchdog.
            timeout_q  <= cnt_expired && !bus.done && owner_req;
          end else begin
            hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.grant_idx   = grant_idx_q;
  assign bus.grant_valid = (state_q == StGrant);
  assign bus.busy        = (state_q == StGrant);
  assign bus.timeout     = timeout_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Bench for rr_arbiter8: directed vector table, hand-written corner sequences and
// randomized traffic, all checked against a cycle-level behavioural model.
module tb_rr_arbiter8;

  localparam int unsigned MaxHold = 8;

  logic clk;
  logic rst_n;

  rr_arbiter8_if bus ();

  rr_arbiter8 #(
    .MAX_HOLD(MaxHold),
    .HOLD_W  (8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: who owns the resource, how many cycles the grant has been visible,
  // and which index has top priority next.
  bit m_valid;
  int m_idx;
  int m_ptr;
  int m_held;
  bit m_to;

  task automatic model_step();
    bit expired;
    bit rel;
    bit found;
    int c;
    if (!rst_n) begin
      m_valid = 0; m_idx = 0; m_ptr = 0; m_held = 0; m_to = 0;
    end else if (!m_valid) begin
      m_to = 0;
      if (bus.en && bus.req != 8'h00) begin
        found = 0;
        for (int k = 0; k < 8; k++) begin
          c = (m_ptr + k) % 8;
          if (!found && bus.req[c]) begin
            found = 1;
            m_idx = c;
          end
        end
        m_valid = 1;
        m_held  = 1;
      end
    end else begin
      expired = (m_held == int'(MaxHold));
      rel     = bus.done || !bus.req[m_idx] || expired;
      if (rel) begin
        m_to    = expired && !bus.done && bus.req[m_idx];
        m_valid = 0;
        m_ptr   = (m_idx + 1) % 8;
      end else begin
        m_held++;
        m_to = 0;
      end
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
    chk("model_valid", 32'(bus.grant_valid), 32'(m_valid));
    chk("model_busy", 32'(bus.busy), 32'(m_valid));
    chk("model_idx", 32'(bus.grant_idx), 32'(m_idx));
    chk("model_timeout", 32'(bus.timeout), 32'(m_to));
  endtask

  typedef struct {
    logic       rst_n;
    logic       en;
    logic [7:0] req;
    logic       done;
    logic       exp_valid;
    logic [2:0] exp_idx;
    logic       exp_to;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic e, input logic [7:0] q, input logic d,
                     input logic v, input logic [2:0] i, input logic t);
    vec_t x;
    x.rst_n = r; x.en = e; x.req = q; x.done = d;
    x.exp_valid = v; x.exp_idx = i; x.exp_to = t;
    vecs.push_back(x);
  endtask

  int n;

  initial begin
    rst_n    = 1'b0;
    bus.en   = 1'b1;
    bus.req  = 8'hFF;
    bus.done = 1'b0;
    m_valid = 0; m_idx = 0; m_ptr = 0; m_held = 0; m_to = 0;

    // Reset held two cycles, then full rotation 0..7,0, then priority skips.
    add(1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 3'd0, 1'b0);
    add(1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 3'd0, 1'b0);
    for (int k = 0; k < 9; k++) begin
      add(1'b1, 1'b1, 8'hFF, 1'b0, 1'b1, 3'(k % 8), 1'b0);
      add(1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 3'(k % 8), 1'b0);
    end
    add(1'b1, 1'b1, 8'h04, 1'b0, 1'b1, 3'd2, 1'b0);
    add(1'b1, 1'b1, 8'h04, 1'b1, 1'b0, 3'd2, 1'b0);
    add(1'b1, 1'b1, 8'h05, 1'b0, 1'b1, 3'd0, 1'b0);
    add(1'b1, 1'b1, 8'h05, 1'b1, 1'b0, 3'd0, 1'b0);
    add(1'b1, 1'b1, 8'h81, 1'b0, 1'b1, 3'd7, 1'b0);
    add(1'b1, 1'b1, 8'h81, 1'b1, 1'b0, 3'd7, 1'b0);

    for (int v = 0; v < vecs.size(); v++) begin
      rst_n    = vecs[v].rst_n;
      bus.en   = vecs[v].en;
      bus.req  = vecs[v].req;
      bus.done = vecs[v].done;
      cycle();
      chk($sformatf("vec%0d_valid", v), 32'(bus.grant_valid), 32'(vecs[v].exp_valid));
      chk($sformatf("vec%0d_idx", v), 32'(bus.grant_idx), 32'(vecs[v].exp_idx));
      chk($sformatf("vec%0d_timeout", v), 32'(bus.timeout), 32'(vecs[v].exp_to));
    end

    // Watchdog: idx 4 held with no done, released after exactly MaxHold cycles.
    bus.done = 1'b0;
    bus.req  = 8'h10;
    cycle();
    chk("wd_grant_idx", 32'(bus.grant_idx), 32'd4);
    n = 0;
    while (bus.grant_valid && n < 20) begin
      n++;
      cycle();
    end
    chk("wd_hold_cycles", 32'(n), 32'(MaxHold));
    chk("wd_timeout_pulse", 32'(bus.timeout), 32'd1);
    bus.req = 8'hFF;
    cycle();
    chk("wd_timeout_cleared", 32'(bus.timeout), 32'd0);
    chk("wd_next_idx", 32'(bus.grant_idx), 32'd5);
    bus.done = 1'b1;
    cycle();
    chk("wd_done_release", 32'(bus.grant_valid), 32'd0);

    // done coinciding with counter expiry counts as a normal release.
    bus.done = 1'b0;
    bus.req  = 8'h40;
    cycle();
    chk("wd2_grant_idx", 32'(bus.grant_idx), 32'd6);
    for (int i = 0; i < 7; i++) cycle();
    chk("wd2_still_valid", 32'(bus.grant_valid), 32'd1);
    bus.done = 1'b1;
    cycle();
    chk("wd2_released", 32'(bus.grant_valid), 32'd0);
    chk("wd2_no_timeout", 32'(bus.timeout), 32'd0);
    bus.done = 1'b0;

    // en dropped mid-grant keeps the grant; dropping req releases; en=0 blocks regrant.
    bus.req = 8'h04;
    bus.en  = 1'b1;
    cycle();
    chk("en_grant_idx", 32'(bus.grant_idx), 32'd2);
    bus.en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("en_grant_persists", 32'(bus.grant_valid), 32'd1);
    end
    bus.req = 8'h00;
    cycle();
    chk("drop_release", 32'(bus.grant_valid), 32'd0);
    bus.req = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("en_low_no_grant", 32'(bus.grant_valid), 32'd0);
    end

    // Reset in the middle of a grant of idx 6.
    bus.en  = 1'b1;
    bus.req = 8'h40;
    cycle();
    chk("mr_grant_idx", 32'(bus.grant_idx), 32'd6);
    cycle();
    rst_n = 1'b0;
    cycle();
    chk("mr_valid", 32'(bus.grant_valid), 32'd0);
    chk("mr_idx", 32'(bus.grant_idx), 32'd0);
    chk("mr_timeout", 32'(bus.timeout), 32'd0);
    rst_n   = 1'b1;
    bus.req = 8'hFF;
    cycle();
    chk("mr_restart_idx", 32'(bus.grant_idx), 32'd0);
    chk("mr_restart_valid", 32'(bus.grant_valid), 32'd1);

    // Randomized traffic; req changes rarely so watchdog expiries occur.
    for (int i = 0; i < 3000; i++) begin
      rst_n    = ($urandom_range(0, 199) != 0);
      bus.en   = ($urandom_range(0, 3) != 0);
      bus.done = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 5) == 0) bus.req = 8'($urandom);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rr_arbiter8.md
# rr_arbiter8

Eight-way round-robin arbiter with grant hold and hold-time watchdog. It sits directly upstream of the team's 3-to-8 decoder: it registers a 3-bit grant index, and the decoder expands that index into a one-hot grant, gated by `grant_valid`. A grant is held until the owner signals `done`, drops its request, or exceeds the hold limit. Priority then rotates to the requester after the released one.

## Interface
- `MAX_HOLD`, default 8: maximum cycles a grant is held before forced release; legal range 2..255.
- `HOLD_W`, default 8: width of the hold counter; must satisfy 2^HOLD_W > MAX_HOLD.

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `en`  in  1  arbitration enable; sampled only in IDLE.
- `req`  in  8  request vector; `req[i]` means requester i wants the resource.
- `done`  in  1  owner release pulse; sampled only in GRANT.
- `grant_idx`  out  3  index of current/last owner; drives decoder input.
- `grant_valid`  out  1  grant active; downstream gates one-hot with this.
- `busy`  out  1  equals `grant_valid`; kept for status polling.
- `timeout`  out  1  one-cycle pulse: last grant was force-released by the watchdog.

## Operation
- State machine: two states, IDLE and GRANT.
- Registered state: `state`, `ptr[2:0]` (highest-priority index), `grant_idx`, `hold_cnt[HOLD_W-1:0]`, `timeout`.
- Reset (`rst_n`=0 at edge): state=IDLE, ptr=0, grant_idx=0, grant_valid=0, busy=0, timeout=0, hold_cnt=0. Reset overrides everything, including a grant in progress; no release side effects occur.
- IDLE:
  - If `en`=1 and `req`≠0: select the first set bit scanning ptr, ptr+1, …, ptr+7 (mod 8).
  - On the next edge: grant_idx←winner, state←GRANT, hold_cnt←0.
  - Otherwise remain in IDLE; grant_idx keeps its last value.
- GRANT:
  - Release when any of these hold: `done`=1; `req[grant_idx]`=0; `hold_cnt`==MAX_HOLD-1.
  - On release edge: state←IDLE, ptr←grant_idx+1 (3-bit wrap, 7→0), hold_cnt←0.
  - No release: hold_cnt←hold_cnt+1, all else held.
  - `en` and other `req` bits are ignored in GRANT; deasserting `en` does not revoke a grant.
- `timeout`:
  - Set to 1 on a release edge only when the release cause is solely the counter (`done`=0 and `req[grant_idx]`=1).
  - Otherwise 0, so it is high for exactly one cycle.
  - When `done` and counter expiry coincide, the release counts as normal: timeout=0.
- `grant_idx` is never cleared on release. Consumers must qualify it with `grant_valid`.
- Fairness: after release of index k, index k+1 mod 8 has top priority. A lone requester may be re-granted repeatedly.

## Timing
- Grant latency: `req`/`en` sampled at edge t in IDLE gives grant_valid=1 and the new grant_idx in the cycle after edge t (1 cycle).
- Release latency: cause sampled at edge t gives grant_valid=0 after edge t.
- Minimum grant gap: one IDLE cycle between consecutive grants. Back-to-back grants without an IDLE cycle are not supported.
- Maximum hold: grant_valid is high for at most MAX_HOLD cycles; the counter release fires on the edge where hold_cnt==MAX_HOLD-1.
- Outputs are purely registered, with no combinational paths from inputs to outputs.
- Downstream decoder output is valid in the same cycle as grant_valid (combinational from grant_idx).

## Test plan
- Reset and idle:
  - Hold rst_n=0 for 2 cycles with req=8'hFF, en=1 → grant_valid=0, grant_idx=0, timeout=0 throughout.
  - Release reset → grant_idx=0, grant_valid=1 one cycle later.
- Rotation: req=8'hFF constant, `done` pulsed each grant cycle → grant_idx sequence 0,1,2,…,7,0 with an IDLE cycle between each; verifies 7→0 wrap.
- Priority skip: ptr=3 (after releasing idx 2), req=8'b0000_0101 → grant_idx=0. Next, req=8'b1000_0001 → grant_idx=7.
- Watchdog, MAX_HOLD=8:
  - Grant idx 4, keep req[4]=1, done=0 → grant_valid high exactly 8 cycles, then timeout=1 for 1 cycle, next grant starts at idx 5 priority.
  - Repeat with done=1 on the 8th cycle → timeout=0.
- Request drop and en:
  - During a grant of idx 2, deassert en → grant persists.
  - Drop req[2] → release next edge; with en=0, no new grant while in IDLE.
- Mid-grant reset: assert rst_n=0 during a grant of idx 6 → next cycle grant_valid=0, grant_idx=0, timeout=0; after reset, arbitration restarts from ptr=0.
